// File: rtl/qua_lsp_pkg.sv
// Shared constants for the Qua_Lsp resource arbiter: default bus widths, requester indices, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package qua_lsp_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_OP_W   = 16;

  // Requester slots as wired in the Qua_Lsp top level. Under fixed priority,
  // slot 0 can starve the others, so the slot order is significant.
  localparam int REQ_PREV_UPDATE = 0;
  localparam int REQ_EXPAND      = 1;
  localparam int REQ_STABILITY   = 2;
  localparam int REQ_GET_QUANT   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  // Width of a requester index. The result is never 0, even for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qua_lsp_arb_pick.sv
// Combinational winner select: request vector (+ round-robin pointer) -> one-hot winner and its index.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller samples the result only while it is idle.
//
// Ports: req_i request vector; ptr_i last winner (round-robin build only);
//        win_vld_o any request present; win_oh_o one-hot winner; win_idx_o winner index.
// Build option QUA_LSP_ARB_ROUND_ROBIN_EN selects round-robin. If it is not defined, the
// lowest index wins.
module qua_lsp_arb_pick
  import qua_lsp_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = idx_w(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
`ifdef QUA_LSP_ARB_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0] ptr_i,
`endif
  output logic             win_vld_o,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [IDX_W-1:0] win_idx_o
);

`ifdef QUA_LSP_ARB_ROUND_ROBIN_EN
  int cand;

  // Search starts just after the previous winner and wraps. The previous
  // winner is checked last, at k == N_REQ.
  always_comb begin
    win_vld_o = 1'b0;
    win_oh_o  = '0;
    win_idx_o = '0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr_i) + k) % N_REQ;
      if (!win_vld_o && req_i[cand]) begin
        win_vld_o      = 1'b1;
        win_oh_o[cand] = 1'b1;
        win_idx_o      = IDX_W'(cand);
      end
    end
  end
`else
  always_comb begin
    win_vld_o = 1'b0;
    win_oh_o  = '0;
    win_idx_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld_o && req_i[i]) begin
        win_vld_o   = 1'b1;
        win_oh_o[i] = 1'b1;
        win_idx_o   = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/qua_lsp_resource_arbiter.sv
// Grants one of N_REQ LSP-quantizer FSMs the shared scratch memory port and add/sub/L_add units.
// Latency: grant 1 edge after req is sampled in IDLE; the bus is steered combinationally while granted.
// Backpressure: no preemption; losers wait while the owner holds req; there is one forced IDLE cycle after each release.
//
// Ports: clk, reset (async active-low); req per-requester request (held for the transaction);
//        req* packed per-requester buses, requester i at [i*W +: W];
//        gnt one-hot grant, owner owner index (0 when idle), busy grant active (all registered);
//        mem*/add*/sub*/L_add* shared outputs, all 0 when no grant is active.
// Build option QUA_LSP_ARB_ROUND_ROBIN_EN selects round-robin arbitration. The default is
// fixed priority, where the lowest index wins.
module qua_lsp_resource_arbiter
  import qua_lsp_pkg::*;
#(
  parameter  int N_REQ  = DEF_N_REQ,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int OP_W   = DEF_OP_W,
  localparam int IDX_W  = idx_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] reqMemReadAddr,
  input  logic [N_REQ*ADDR_W-1:0] reqMemWriteAddr,
  input  logic [N_REQ*DATA_W-1:0] reqMemOut,
  input  logic [N_REQ-1:0]        reqMemWriteEn,
  input  logic [N_REQ*OP_W-1:0]   reqAddOutA,
  input  logic [N_REQ*OP_W-1:0]   reqAddOutB,
  input  logic [N_REQ*OP_W-1:0]   reqSubOutA,
  input  logic [N_REQ*OP_W-1:0]   reqSubOutB,
  input  logic [N_REQ*DATA_W-1:0] reqL_addOutA,
  input  logic [N_REQ*DATA_W-1:0] reqL_addOutB,
  output logic [N_REQ-1:0]        gnt,
  output logic [IDX_W-1:0]        owner,
  output logic                    busy,
  output logic [ADDR_W-1:0]       memReadAddr,
  output logic [ADDR_W-1:0]       memWriteAddr,
  output logic [DATA_W-1:0]       memOut,
  output logic                    memWriteEn,
  output logic [OP_W-1:0]         addOutA,
  output logic [OP_W-1:0]         addOutB,
  output logic [OP_W-1:0]         subOutA,
  output logic [OP_W-1:0]         subOutB,
  output logic [DATA_W-1:0]       L_addOutA,
  output logic [DATA_W-1:0]       L_addOutB
);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             busy_q, busy_d;

  logic             win_vld;
  logic [N_REQ-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;

`ifdef QUA_LSP_ARB_ROUND_ROBIN_EN
  // Index of the last winner. It resets to the top slot so that requester 0 wins first.
  logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

  qua_lsp_arb_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i     (req),
`ifdef QUA_LSP_ARB_ROUND_ROBIN_EN
    .ptr_i     (ptr_q),
`endif
    .win_vld_o (win_vld),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    busy_d  = busy_q;
`ifdef QUA_LSP_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_OWNED;
          gnt_d   = win_oh;
          owner_d = win_idx;
          busy_d  = 1'b1;
`ifdef QUA_LSP_ARB_ROUND_ROBIN_EN
          ptr_d   = win_idx;
`endif
        end
      end
      ST_OWNED: begin
        // Release goes back through IDLE rather than straight to the next
        // winner. The empty cycle keeps two owners' writes from abutting.
        if (!req[owner_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          owner_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        owner_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
`ifdef QUA_LSP_ARB_ROUND_ROBIN_EN
      ptr_q   <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
`ifdef QUA_LSP_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Steer the owner's slice onto the shared units. Every output is forced to 0
  // when no grant is active. The write enable is also gated by the owner's own
  // grant bit, so a requester without a grant can never write.
  always_comb begin
    memReadAddr  = '0;
    memWriteAddr = '0;
    memOut       = '0;
    memWriteEn   = 1'b0;
    addOutA      = '0;
    addOutB      = '0;
    subOutA      = '0;
    subOutB      = '0;
    L_addOutA    = '0;
    L_addOutB    = '0;
    if (busy_q) begin
      memReadAddr  = reqMemReadAddr [owner_q*ADDR_W +: ADDR_W];
      memWriteAddr = reqMemWriteAddr[owner_q*ADDR_W +: ADDR_W];
      memOut       = reqMemOut      [owner_q*DATA_W +: DATA_W];
      memWriteEn   = reqMemWriteEn[owner_q] & gnt_q[owner_q];
      addOutA      = reqAddOutA     [owner_q*OP_W   +: OP_W];
      addOutB      = reqAddOutB     [owner_q*OP_W   +: OP_W];
      subOutA      = reqSubOutA     [owner_q*OP_W   +: OP_W];
      subOutB      = reqSubOutB     [owner_q*OP_W   +: OP_W];
      L_addOutA    = reqL_addOutA   [owner_q*DATA_W +: DATA_W];
      L_addOutB    = reqL_addOutB   [owner_q*DATA_W +: DATA_W];
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_qua_lsp_resource_arbiter.sv
// Self-checking bench for qua_lsp_resource_arbiter: a vector table plus hand-built corner-case sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_qua_lsp_resource_arbiter;
  import qua_lsp_pkg::*;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int OW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] reqMemReadAddr, reqMemWriteAddr;
  logic [N*DW-1:0] reqMemOut, reqL_addOutA, reqL_addOutB;
  logic [N-1:0]    reqMemWriteEn;
  logic [N*OW-1:0] reqAddOutA, reqAddOutB, reqSubOutA, reqSubOutB;
  logic [N-1:0]    gnt;
  logic [1:0]      owner;
  logic            busy;
  logic [AW-1:0]   memReadAddr, memWriteAddr;
  logic [DW-1:0]   memOut, L_addOutA, L_addOutB;
  logic            memWriteEn;
  logic [OW-1:0]   addOutA, addOutB, subOutA, subOutB;

  // Per-requester bus values, packed onto the DUT ports below.
  logic [AW-1:0] rd_a [N];
  logic [AW-1:0] wr_a [N];
  logic [DW-1:0] wd   [N];
  logic [OW-1:0] aa   [N];
  logic [OW-1:0] ab   [N];
  logic [OW-1:0] sa   [N];
  logic [OW-1:0] sb   [N];
  logic [DW-1:0] la   [N];
  logic [DW-1:0] lb   [N];
  logic [N-1:0]  we;

  always_comb begin
    reqMemReadAddr  = '0;
    reqMemWriteAddr = '0;
    reqMemOut       = '0;
    reqAddOutA      = '0;
    reqAddOutB      = '0;
    reqSubOutA      = '0;
    reqSubOutB      = '0;
    reqL_addOutA    = '0;
    reqL_addOutB    = '0;
    for (int i = 0; i < N; i++) begin
      reqMemReadAddr [i*AW +: AW] = rd_a[i];
      reqMemWriteAddr[i*AW +: AW] = wr_a[i];
      reqMemOut      [i*DW +: DW] = wd[i];
      reqAddOutA     [i*OW +: OW] = aa[i];
      reqAddOutB     [i*OW +: OW] = ab[i];
      reqSubOutA     [i*OW +: OW] = sa[i];
      reqSubOutB     [i*OW +: OW] = sb[i];
      reqL_addOutA   [i*DW +: DW] = la[i];
      reqL_addOutB   [i*DW +: DW] = lb[i];
    end
  end
  assign reqMemWriteEn = we;

  qua_lsp_resource_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .reqMemReadAddr  (reqMemReadAddr),
    .reqMemWriteAddr (reqMemWriteAddr),
    .reqMemOut       (reqMemOut),
    .reqMemWriteEn   (reqMemWriteEn),
    .reqAddOutA      (reqAddOutA),
    .reqAddOutB      (reqAddOutB),
    .reqSubOutA      (reqSubOutA),
    .reqSubOutB      (reqSubOutB),
    .reqL_addOutA    (reqL_addOutA),
    .reqL_addOutB    (reqL_addOutB),
    .gnt             (gnt),
    .owner           (owner),
    .busy            (busy),
    .memReadAddr     (memReadAddr),
    .memWriteAddr    (memWriteAddr),
    .memOut          (memOut),
    .memWriteEn      (memWriteEn),
    .addOutA         (addOutA),
    .addOutB         (addOutB),
    .subOutA         (subOutA),
    .subOutB         (subOutB),
    .L_addOutA       (L_addOutA),
    .L_addOutB       (L_addOutB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic [1:0]   owner;
    logic         busy;
  } exp_t;

  typedef struct packed {
    logic [N-1:0] req;
    logic [N-1:0] we;
    logic [N-1:0] gnt;
    logic [1:0]   owner;
    logic         busy;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[18];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h, expected %0h", tag, what, act, exp);
    end
  endtask

  task automatic push_exp(input logic [N-1:0] g, input logic [1:0] o, input logic b);
    exp_t e;
    e.gnt   = g;
    e.owner = o;
    e.busy  = b;
    sb_q.push_back(e);
  endtask

  // Pops one expectation and compares the registered state plus every shared
  // output. The expected outputs are the expected owner's slice, or 0 when idle.
  task automatic check_all(input string tag);
    exp_t e;
    logic [1:0] o;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s.scoreboard: got empty queue, expected an entry", tag);
      return;
    end
    e = sb_q.pop_front();
    o = e.owner;
    chk(tag, "gnt",   64'(gnt),   64'(e.gnt));
    chk(tag, "owner", 64'(owner), 64'(e.owner));
    chk(tag, "busy",  64'(busy),  64'(e.busy));
    chk(tag, "memReadAddr",  64'(memReadAddr),  e.busy ? 64'(rd_a[o]) : 64'd0);
    chk(tag, "memWriteAddr", 64'(memWriteAddr), e.busy ? 64'(wr_a[o]) : 64'd0);
    chk(tag, "memOut",       64'(memOut),       e.busy ? 64'(wd[o])   : 64'd0);
    chk(tag, "memWriteEn",   64'(memWriteEn),   e.busy ? 64'(we[o])   : 64'd0);
    chk(tag, "addOutA",      64'(addOutA),      e.busy ? 64'(aa[o])   : 64'd0);
    chk(tag, "addOutB",      64'(addOutB),      e.busy ? 64'(ab[o])   : 64'd0);
    chk(tag, "subOutA",      64'(subOutA),      e.busy ? 64'(sa[o])   : 64'd0);
    chk(tag, "subOutB",      64'(subOutB),      e.busy ? 64'(sb[o])   : 64'd0);
    chk(tag, "L_addOutA",    64'(L_addOutA),    e.busy ? 64'(la[o])   : 64'd0);
    chk(tag, "L_addOutB",    64'(L_addOutB),    e.busy ? 64'(lb[o])   : 64'd0);
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_own;

    // Vector table, applied one vector per clock starting from IDLE.
    //            req      we       gnt      owner busy
    vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}; // idle stays idle
    vecs[1]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1}; // single request, req 2 writes
    vecs[2]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1}; // held
    vecs[3]  = '{4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0}; // owner 2 drops, req 1 waiting
    vecs[4]  = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1}; // req 1 granted after gap
    vecs[5]  = '{4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b1}; // ungranted 3 tries to write
    vecs[6]  = '{4'b1000, 4'b1000, 4'b0000, 2'd0, 1'b0}; // owner 1 releases
    vecs[7]  = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1}; // req 3 granted
    vecs[8]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}; // release
    vecs[9]  = '{4'b0001, 4'b1001, 4'b0001, 2'd0, 1'b1}; // req 0 owns and writes
    vecs[10] = '{4'b1001, 4'b1000, 4'b0001, 2'd0, 1'b1}; // isolation: only 3 writes, not granted
    vecs[11] = '{4'b1000, 4'b1000, 4'b0000, 2'd0, 1'b0}; // owner 0 releases
    vecs[12] = '{4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1}; // waiting req 3 granted
    vecs[13] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}; // release
    vecs[14] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}; // idle
    vecs[15] = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1}; // one-cycle owner: grant
    vecs[16] = '{4'b0000, 4'b0010, 4'b0000, 2'd0, 1'b0}; // dropped in first owned cycle
    vecs[17] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}; // stays idle, outputs 0

    for (int i = 0; i < N; i++) begin
      rd_a[i] = AW'(12'h100 + i);
      wr_a[i] = AW'(12'h200 + i);
      wd[i]   = 32'hD000_0000 + 32'(i);
      aa[i]   = OW'(16'h1000 + i);
      ab[i]   = OW'(16'h2000 + i);
      sa[i]   = OW'(16'h3000 + i);
      sb[i]   = OW'(16'h4000 + i);
      la[i]   = 32'hA000_0000 + 32'(i);
      lb[i]   = 32'hB000_0000 + 32'(i);
    end
    wr_a[REQ_STABILITY] = 12'h3A0;
    wd[REQ_STABILITY]   = 32'h0000_1234;
    aa[REQ_PREV_UPDATE] = 16'h0011;
    aa[REQ_GET_QUANT]   = 16'h7FFF;
    we  = '1;
    req = '0;

    // Reset state. Enables are high, so the outputs must still read 0.
    reset = 1'b0;
    step();
    step();
    push_exp(4'b0000, 2'd0, 1'b0);
    check_all("reset");
    reset = 1'b1;
    we    = '0;
    step();

    // Table
    for (int i = 0; i < 18; i++) begin
      req = vecs[i].req;
      we  = vecs[i].we;
      push_exp(vecs[i].gnt, vecs[i].owner, vecs[i].busy);
      step();
      check_all($sformatf("vec%0d", i));
    end

    // A request pulse that drops between edges is never seen.
    req = 4'b0100;
    #3;
    req = 4'b0000;
    push_exp(4'b0000, 2'd0, 1'b0);
    step();
    check_all("pulse");

    // Reset mid-grant clears everything asynchronously. A held request is granted again after release.
    req = 4'b0010;
    we  = 4'b0010;
    push_exp(4'b0010, 2'd1, 1'b1);
    step();
    check_all("pre_reset");
    #2;
    reset = 1'b0;
    #1;
    push_exp(4'b0000, 2'd0, 1'b0);
    check_all("async_reset");
    step();
    reset = 1'b1;
    step();
    step();
    push_exp(4'b0010, 2'd1, 1'b1);
    check_all("post_reset");

    // Clean restart so that the contention order starts from the reset pointer.
    req   = '0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Contention: all four request and each owner holds for 3 cycles.
    we  = 4'b1111;
    req = 4'b1111;
    step();
    for (int g = 0; g < 5; g++) begin
`ifdef QUA_LSP_ARB_ROUND_ROBIN_EN
      exp_own = 2'(g % N);
`else
      exp_own = 2'd0;
`endif
      push_exp(4'(1 << exp_own), exp_own, 1'b1);
      check_all($sformatf("contend%0d", g));
      step();
      step();
      req[owner] = 1'b0;
      push_exp(4'b0000, 2'd0, 1'b0);
      step();
      check_all($sformatf("contend_gap%0d", g));
      req = 4'b1111;
      step();
    end
    req = '0;
    step();
    step();
    push_exp(4'b0000, 2'd0, 1'b0);
    check_all("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
